// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline hazard/stall sequencer for the 5-stage core, sitting beside the
// bypassing regfile. It detects load-use hazards, which forwarding cannot
// cover because load data only exists after MEM. It holds multi-cycle
// mul/div ops in EX and drives the per-stage stall and bubble controls.
// An exception/eret flush aborts any sequence in progress.
//
// Parameters:
//   MUL_LAT   cycles EX is held for a multiply (>=1). The multiplier has no
//             ready signal, so its latency is counted here.
//   DIV_MAXW  divider watchdog. This is the maximum number of cycles spent
//             in DIV_WAIT before the op is released with md_cancel.
//
// Build option:
//   HAZARD_PERF_CNT_EN  when defined, adds the perf_lu_cnt and perf_md_cnt
//                       counters. When undefined, both outputs are tied to 0.
//
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   flush                         exception/eret flush
//   id_valid, id_rs_re/id_rs,
//   id_rt_re/id_rt                ID instruction and its source reads
//   ex_valid, ex_is_load, ex_we,
//   ex_waddr                      EX instruction and its destination
//   ex_is_mul, ex_is_div          mul/div op held in EX
//   div_ready                     divider result valid (level)
//   stall[5:0]                    hold bits: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
//   id_ex_bubble, ex_mem_bubble   load a NOP into ID/EX or EX/MEM
//   md_start, md_cancel, md_done  1-cycle mul/div control pulses
//   perf_lu_cnt, perf_md_cnt      stall-cycle performance counters
//
// States:
//   state    | meaning
//   IDLE     | no mul/div in progress; load-use hazards are detected here
//   MUL_WAIT | multiply held in EX; cnt counts down the remaining hold cycles
//   DIV_WAIT | divide held in EX; cnt counts up elapsed cycles for the watchdog
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MUL_LAT  = 4,
    parameter int DIV_MAXW = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        id_valid,
    input  logic        id_rs_re,
    input  logic [4:0]  id_rs,
    input  logic        id_rt_re,
    input  logic [4:0]  id_rt,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_we,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_is_mul,
    input  logic        ex_is_div,
    input  logic        div_ready,
    output logic [5:0]  stall,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        md_start,
    output logic        md_cancel,
    output logic        md_done,
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_md_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    localparam logic [5:0] STALL_LU = 6'b000111;   // PC, IF, ID held
    localparam logic [5:0] STALL_MD = 6'b001111;   // PC, IF, ID, EX held
    localparam logic [6:0] MUL_INIT = 7'(MUL_LAT - 1);
    localparam logic [6:0] DIV_LAST = 7'(DIV_MAXW - 1);

    state_t     state;
    state_t     state_nxt;
    logic [6:0] cnt;
    logic [6:0] cnt_nxt;
    logic       lu_hit;

    // x0 is hard-wired to zero, so a load targeting it can never be a hazard.
    assign lu_hit = id_valid & ex_valid & ex_is_load & ex_we & (ex_waddr != 5'd0)
                  & ((id_rs_re & (id_rs == ex_waddr)) | (id_rt_re & (id_rt == ex_waddr)));

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        stall         = 6'b000000;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        md_start      = 1'b0;
        md_cancel     = 1'b0;
        md_done       = 1'b0;

        if (rst) begin
            state_nxt = IDLE;
            cnt_nxt   = 7'd0;
        end else if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = 7'd0;
            md_cancel = (state != IDLE);
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_nxt = 7'd0;
                    if (ex_valid & ex_is_mul) begin
                        stall         = STALL_MD;
                        ex_mem_bubble = 1'b1;
                        md_start      = 1'b1;
                        cnt_nxt       = MUL_INIT;
                        state_nxt     = MUL_WAIT;
                    end else if (ex_valid & ex_is_div) begin
                        stall         = STALL_MD;
                        ex_mem_bubble = 1'b1;
                        md_start      = 1'b1;
                        state_nxt     = DIV_WAIT;
                    end else if (lu_hit) begin
                        // The load advances, so a single bubble resolves it.
                        stall        = STALL_LU;
                        id_ex_bubble = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    if (cnt != 7'd0) begin
                        stall         = STALL_MD;
                        ex_mem_bubble = 1'b1;
                        cnt_nxt       = cnt - 7'd1;
                    end else begin
                        md_done   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                DIV_WAIT: begin
                    if (div_ready) begin
                        md_done   = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = 7'd0;
                    end else if (cnt == DIV_LAST) begin
                        md_cancel = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = 7'd0;
                    end else begin
                        stall         = STALL_MD;
                        ex_mem_bubble = 1'b1;
                        cnt_nxt       = cnt + 7'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 7'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 7'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // The stall pattern identifies the cause: 000111 only comes from a
    // load-use hazard and 001111 only from a held mul/div.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_cnt <= 32'd0;
            perf_md_cnt <= 32'd0;
        end else begin
            if (stall == STALL_LU) perf_lu_cnt <= perf_lu_cnt + 32'd1;
            if (stall == STALL_MD) perf_md_cnt <= perf_md_cnt + 32'd1;
        end
    end
`else
    assign perf_lu_cnt = 32'd0;
    assign perf_md_cnt = 32'd0;
`endif

endmodule
